// File: rtl/simon_pkg.sv
// +----------------------------------------------------------------------+
// | simon_pkg : shared widths and owner encoding for the Simon memory    |
// | arbiter slice.                                                       |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package simon_pkg;

  localparam int c_addr_w = 4;
  localparam int c_data_w = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_WR   = 2'd1,
    OWN_BL   = 2'd2,
    OWN_CK   = 2'd3
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// +----------------------------------------------------------------------+
// | rr_picker : two-way reader selection (blinker / checker).            |
// | SEQ_ARB_RR_EN selects round-robin; otherwise blinker has priority.   |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_picker (
  input  logic clk,
  input  logic reset,
  input  logic bl_req,
  input  logic ck_req,
  input  logic grant_bl,
  input  logic grant_ck,
  output logic pick_bl,
  output logic pick_ck
);

`ifdef SEQ_ARB_RR_EN
  // Set after a blinker grant so the checker wins the next reader tie.
  logic r_prefer_ck;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prefer_ck <= 1'b0;
    end else if (grant_bl) begin
      r_prefer_ck <= 1'b1;
    end else if (grant_ck) begin
      r_prefer_ck <= 1'b0;
    end
  end

  assign pick_ck = ck_req && (!bl_req || r_prefer_ck);
`else
  logic w_unused;
  assign w_unused = ^{clk, reset, grant_bl, grant_ck};
  assign pick_ck  = ck_req && !bl_req;
`endif

  assign pick_bl = bl_req && !pick_ck;

endmodule

`default_nettype wire

// File: rtl/seq_mem_arbiter.sv
// +----------------------------------------------------------------------+
// | seq_mem_arbiter : registered-grant arbiter sharing the Simon step    |
// | memory between writer, blinker and checker. Option: SEQ_ARB_RR_EN.  |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_mem_arbiter
  import simon_pkg::*;
#(
  parameter int ADDR_W   = c_addr_w,
  parameter int DATA_W   = c_data_w,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              bl_req,
  input  logic [ADDR_W-1:0] bl_addr,
  output logic              bl_gnt,
  output logic              bl_rvalid,
  input  logic              ck_req,
  input  logic [ADDR_W-1:0] ck_addr,
  output logic              ck_gnt,
  output logic              ck_rvalid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                c_hold_w   = $clog2(LOCK_MAX);
  localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(LOCK_MAX - 1);

  owner_t              r_owner;
  owner_t              w_owner_nxt;
  logic [c_hold_w-1:0] r_hold;
  logic                r_bl_rvalid;
  logic                r_ck_rvalid;

  logic w_own_req, w_others, w_limit_hit, w_arb;
  logic w_cand_wr, w_cand_bl, w_cand_ck;
  logic w_pick_bl, w_pick_ck;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= OWN_NONE;
      r_hold  <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      if (w_owner_nxt != r_owner) begin
        r_hold <= '0;
      end else if (r_hold != c_hold_max) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  always_comb begin
    w_own_req = 1'b0;
    w_others  = 1'b0;
    case (r_owner)
      OWN_WR:  begin w_own_req = wr_req; w_others = bl_req | ck_req; end
      OWN_BL:  begin w_own_req = bl_req; w_others = wr_req | ck_req; end
      OWN_CK:  begin w_own_req = ck_req; w_others = wr_req | bl_req; end
      default: begin w_own_req = 1'b0;   w_others = wr_req | bl_req | ck_req; end
    endcase
  end

  // A requester dropping on the limit edge is a plain release, not a forced hand-off.
  assign w_limit_hit = w_own_req && (r_hold == c_hold_max) && w_others;
  assign w_arb       = (r_owner == OWN_NONE) || !w_own_req || w_limit_hit;
  assign w_cand_wr   = wr_req && !(w_limit_hit && (r_owner == OWN_WR));
  assign w_cand_bl   = bl_req && !(w_limit_hit && (r_owner == OWN_BL));
  assign w_cand_ck   = ck_req && !(w_limit_hit && (r_owner == OWN_CK));

  rr_picker u_picker (
    .clk      (clk),
    .reset    (reset),
    .bl_req   (w_cand_bl),
    .ck_req   (w_cand_ck),
    .grant_bl (w_owner_nxt == OWN_BL && r_owner != OWN_BL),
    .grant_ck (w_owner_nxt == OWN_CK && r_owner != OWN_CK),
    .pick_bl  (w_pick_bl),
    .pick_ck  (w_pick_ck)
  );

  always_comb begin
    w_owner_nxt = r_owner;
    if (w_arb) begin
      if (w_cand_wr)      w_owner_nxt = OWN_WR;
      else if (w_pick_bl) w_owner_nxt = OWN_BL;
      else if (w_pick_ck) w_owner_nxt = OWN_CK;
      else                w_owner_nxt = OWN_NONE;
    end
  end

  always_comb begin
    wr_gnt      = (r_owner == OWN_WR);
    bl_gnt      = (r_owner == OWN_BL);
    ck_gnt      = (r_owner == OWN_CK);
    mem_rw      = (r_owner == OWN_WR) && wr_req;
    mem_wdata   = wr_data;
    mem_address = '0;
    case (r_owner)
      OWN_WR:  mem_address = wr_addr;
      OWN_BL:  mem_address = bl_addr;
      OWN_CK:  mem_address = ck_addr;
      default: mem_address = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bl_rvalid <= 1'b0;
      r_ck_rvalid <= 1'b0;
    end else begin
      r_bl_rvalid <= (r_owner == OWN_BL) && bl_req;
      r_ck_rvalid <= (r_owner == OWN_CK) && ck_req;
    end
  end

  assign bl_rvalid = r_bl_rvalid;
  assign ck_rvalid = r_ck_rvalid;
  assign rd_data   = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_seq_mem_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_seq_mem_arbiter : directed and random stimulus for seq_mem_arbiter|
// | against a cycle-level ownership model and a 16x2 memory model.      |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seq_mem_arbiter;

  localparam int LOCK_MAX = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req, bl_req, ck_req;
  logic [3:0] wr_addr, bl_addr, ck_addr;
  logic [1:0] wr_data;
  logic       wr_gnt, bl_gnt, ck_gnt, bl_rvalid, ck_rvalid, mem_rw;
  logic [1:0] rd_data, mem_wdata, mem_rdata;
  logic [3:0] mem_address;

  logic [1:0] mem [16];

  int total = 0;
  int bad   = 0;

  // Model: 0 none, 1 writer, 2 blinker, 3 checker
  int         m_owner, m_held, m_last;
  logic [1:0] m_mem [16];
  logic       m_bl_rv, m_ck_rv;
  logic [1:0] m_rd;

  seq_mem_arbiter #(.ADDR_W(4), .DATA_W(2), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .bl_req(bl_req), .bl_addr(bl_addr), .bl_gnt(bl_gnt), .bl_rvalid(bl_rvalid),
    .ck_req(ck_req), .ck_addr(ck_addr), .ck_gnt(ck_gnt), .ck_rvalid(ck_rvalid),
    .rd_data(rd_data), .mem_address(mem_address), .mem_rw(mem_rw),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rw) mem[mem_address] <= mem_wdata;
    mem_rdata <= mem[mem_address];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_held = 0; m_last = 3;
    m_bl_rv = 1'b0; m_ck_rv = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs currently driven, then compare.
  task automatic tick();
    bit own_req, others, lim, cw, cb, cc, rr;
    int nxt;
    logic [3:0] exp_addr;
`ifdef SEQ_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    m_bl_rv = (m_owner == 2) && bl_req;
    m_ck_rv = (m_owner == 3) && ck_req;
    if (m_bl_rv) m_rd = m_mem[bl_addr];
    if (m_ck_rv) m_rd = m_mem[ck_addr];
    if (m_owner == 1 && wr_req) m_mem[wr_addr] = wr_data;
    own_req = (m_owner == 1) ? wr_req : (m_owner == 2) ? bl_req : (m_owner == 3) ? ck_req : 1'b0;
    others  = (wr_req && m_owner != 1) || (bl_req && m_owner != 2) || (ck_req && m_owner != 3);
    lim     = own_req && (m_held >= LOCK_MAX) && others;
    nxt     = m_owner;
    if (m_owner == 0 || !own_req || lim) begin
      cw = wr_req && !(lim && m_owner == 1);
      cb = bl_req && !(lim && m_owner == 2);
      cc = ck_req && !(lim && m_owner == 3);
      if (cw)            nxt = 1;
      else if (cb && cc) nxt = (rr && m_last == 2) ? 3 : 2;
      else if (cb)       nxt = 2;
      else if (cc)       nxt = 3;
      else               nxt = 0;
    end
    if (nxt != m_owner) begin
      m_held = (nxt == 0) ? 0 : 1;
      if (nxt >= 2) m_last = nxt;
    end else if (nxt != 0) begin
      m_held++;
    end
    m_owner = nxt;
    @(posedge clk);
    #1;
    exp_addr = (m_owner == 1) ? wr_addr : (m_owner == 2) ? bl_addr : (m_owner == 3) ? ck_addr : 4'd0;
    chk("wr_gnt", 8'(wr_gnt), 8'(m_owner == 1));
    chk("bl_gnt", 8'(bl_gnt), 8'(m_owner == 2));
    chk("ck_gnt", 8'(ck_gnt), 8'(m_owner == 3));
    chk("onehot", 8'($countones({wr_gnt, bl_gnt, ck_gnt}) <= 1), 8'd1);
    chk("bl_rvalid", 8'(bl_rvalid), 8'(m_bl_rv));
    chk("ck_rvalid", 8'(ck_rvalid), 8'(m_ck_rv));
    chk("mem_rw", 8'(mem_rw), 8'(m_owner == 1 && wr_req));
    chk("mem_address", 8'(mem_address), 8'(exp_addr));
    if (m_bl_rv || m_ck_rv) chk("rd_data", 8'(rd_data), 8'(m_rd));
  endtask

  task automatic idle();
    wr_req = 1'b0; bl_req = 1'b0; ck_req = 1'b0;
  endtask

  initial begin
    int n, cnt_g, cnt_v;
    reset = 1'b0;
    idle();
    wr_addr = '0; bl_addr = '0; ck_addr = '0; wr_data = '0;
    model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 2'd0;
    #12;
    chk("reset_wr_gnt", 8'(wr_gnt), 8'd0);
    chk("reset_mem_address", 8'(mem_address), 8'd0);
    reset = 1'b1;
    #4;

    // Preload every location through the writer in one long burst.
    wr_req = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      wr_addr = 4'(i); wr_data = 2'($urandom_range(0, 3));
      tick();
    end
    idle(); tick(); tick();

    // Write 2 to address 3, then read it back through the blinker.
    wr_req = 1'b1; wr_addr = 4'd3; wr_data = 2'd2;
    tick();
    chk("wr_gnt_next", 8'(wr_gnt), 8'd1);
    chk("wr_mem_rw", 8'(mem_rw), 8'd1);
    tick();
    wr_req = 1'b0; bl_req = 1'b1; bl_addr = 4'd3;
    tick();
    chk("bl_gnt_after_wr", 8'(bl_gnt), 8'd1);
    tick();
    chk("bl_rvalid_rd", 8'(bl_rvalid), 8'd1);
    chk("bl_rd_data", 8'(rd_data), 8'd2);
    idle(); tick(); tick();

    // All three from idle: writer first, then readers.
    wr_req = 1'b1; bl_req = 1'b1; ck_req = 1'b1;
    tick();
    chk("simul_wr_first", 8'(wr_gnt), 8'd1);
    wr_req = 1'b0;
    tick();
`ifndef SEQ_ARB_RR_EN
    chk("simul_bl_second", 8'(bl_gnt), 8'd1);
`endif
    if (bl_gnt) bl_req = 1'b0; else ck_req = 1'b0;
    tick();
    chk("simul_last_reader", 8'(bl_gnt | ck_gnt), 8'd1);
    idle(); tick(); tick();

    // Both readers held: hand-off at the hold limit.
    bl_req = 1'b1;
    tick();
    ck_req = 1'b1;
    cnt_g = 1; n = 0;
    while (!ck_gnt && n < 60) begin
      bl_addr = 4'($urandom); ck_addr = 4'($urandom);
      tick(); n++;
      if (bl_gnt) cnt_g++;
    end
    chk("bl_run_len", 8'(cnt_g), 8'(LOCK_MAX));
    cnt_g = 1; n = 0;
    while (!bl_gnt && n < 60) begin
      tick(); n++;
      if (ck_gnt) cnt_g++;
    end
    chk("ck_run_len", 8'(cnt_g), 8'(LOCK_MAX));
    idle(); tick(); tick();

    // Lone blinker for 40 accesses: no gap at the hold limit.
    bl_req = 1'b1; cnt_g = 0; cnt_v = 0;
    for (int i = 0; i < 44; i++) begin
      if (i == 41) bl_req = 1'b0;
      bl_addr = 4'($urandom);
      tick();
      if (bl_gnt) cnt_g++;
      if (bl_rvalid) cnt_v++;
    end
    chk("bl_solo_gnt", 8'(cnt_g), 8'd41);
    chk("bl_solo_rvalid", 8'(cnt_v), 8'd40);
    idle(); tick();

    // Writer arrives mid-burst and waits for the blinker to release.
    bl_req = 1'b1;
    tick(); tick(); tick();
    wr_req = 1'b1; wr_addr = 4'd9; wr_data = 2'd1;
    for (int i = 0; i < 5; i++) tick();
    chk("wr_waits", 8'(wr_gnt), 8'd0);
    bl_req = 1'b0;
    tick();
    tick();
    chk("wr_after_release", 8'(wr_gnt), 8'd1);
    idle(); tick();

    // Reset mid-burst with a read strobe pending.
    ck_req = 1'b1; ck_addr = 4'd5;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    chk("rst_ck_gnt", 8'(ck_gnt), 8'd0);
    chk("rst_ck_rvalid", 8'(ck_rvalid), 8'd0);
    chk("rst_mem_address", 8'(mem_address), 8'd0);
    chk("rst_mem_rw", 8'(mem_rw), 8'd0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    tick();

    // Random traffic with sticky requests so bursts reach the hold limit.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) wr_req = ~wr_req;
      if ($urandom_range(0, 7) == 0) bl_req = ~bl_req;
      if ($urandom_range(0, 7) == 0) ck_req = ~ck_req;
      wr_addr = 4'($urandom); wr_data = 2'($urandom);
      bl_addr = 4'($urandom); ck_addr = 4'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
